// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the fetch/data SDRAM port arbiter.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_GRANT_I = 2'd1,
      ARB_GRANT_D = 2'd2,
      ARB_RELEASE = 2'd3
   } arbstate_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'b00,
      OWN_I    = 2'b01,
      OWN_D    = 2'b10
   } owner_t;

   // Instruction fetches are always full 32-bit words.
   localparam logic [1:0] OPLEN_WORD = 2'b10;

   // Starvation counter width; covers STARVE_LIMIT up to 15.
   localparam int STARVE_W = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundles the fetch, data and downstream SDRAM buses around the arbiter.
interface mem_arbiter_if #(
   parameter int ADDR_W = 25
);

   // Handshake: x_enable is a level request held until the matching x_valid
   // one-cycle pulse is seen; m_enable is held until the single-cycle m_valid.
   logic              i_enable;
   logic [ADDR_W-1:0] i_addr;
   logic              i_valid;
   logic [31:0]       i_rdata;

   logic              d_enable;
   logic [ADDR_W-1:0] d_addr;
   logic              d_rw;
   logic [1:0]        d_oplen;
   logic              d_unsigned;
   logic [31:0]       d_wdata;
   logic              d_valid;
   logic [31:0]       d_rdata;

   logic              m_enable;
   logic [ADDR_W-1:0] m_addr;
   logic              m_rw;
   logic [1:0]        m_oplen;
   logic              m_unsigned;
   logic [31:0]       m_wdata;
   logic              m_valid;
   logic [31:0]       m_rdata;

   // Arbiter view: serves the requesters, drives the SDRAM controller.
   modport slave (
      input  i_enable, i_addr,
      output i_valid, i_rdata,
      input  d_enable, d_addr, d_rw, d_oplen, d_unsigned, d_wdata,
      output d_valid, d_rdata,
      output m_enable, m_addr, m_rw, m_oplen, m_unsigned, m_wdata,
      input  m_valid, m_rdata
   );

   // Environment view: the CPU requesters plus the SDRAM controller.
   modport master (
      output i_enable, i_addr,
      input  i_valid, i_rdata,
      output d_enable, d_addr, d_rw, d_oplen, d_unsigned, d_wdata,
      input  d_valid, d_rdata,
      input  m_enable, m_addr, m_rw, m_oplen, m_unsigned, m_wdata,
      output m_valid, m_rdata
   );

endinterface

// File: rtl/mem_arbiter_arb_prio.sv
// Combinational winner select: data wins ties unless fetch has been starved.
module arb_prio
   import mem_arbiter_pkg::*;
(
   input  logic   i_enable,
   input  logic   d_enable,
   input  logic   starved,
   output owner_t winner
);

   always_comb begin
      winner = OWN_NONE;
      if (i_enable && (!d_enable || starved)) begin
         winner = OWN_I;
      end else if (d_enable) begin
         winner = OWN_D;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one SDRAM controller port between instruction fetch and data access,
// one transaction at a time, with a starvation guard and a grant timeout flag.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W         = 25,
   parameter int STARVE_LIMIT   = 4,
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic                clk,
   input  logic                rst_n,
   mem_arbiter_if.slave        bus,
   output logic [1:0]          owner,
   output logic                timeout_err,
   output arbstate_t           dbg_state,
   output logic [STARVE_W-1:0] dbg_starve
);

   localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
   localparam int                  TMO_W      = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0]    TMO_MAX    = TMO_W'(TIMEOUT_CYCLES);

   arbstate_t           state;
   owner_t              owner_q;
   logic [STARVE_W-1:0] starve_cnt;
   logic [TMO_W-1:0]    tmo_cnt;
   owner_t              winner;
   logic                starved;

   assign starved = (starve_cnt == STARVE_MAX);

   arb_prio u_arb_prio (
      .i_enable (bus.i_enable),
      .d_enable (bus.d_enable),
      .starved  (starved),
      .winner   (winner)
   );

   assign owner      = owner_q;
   assign dbg_state  = state;
   assign dbg_starve = starve_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ARB_IDLE;
         owner_q      <= OWN_NONE;
         starve_cnt   <= '0;
         tmo_cnt      <= '0;
         timeout_err  <= 1'b0;
         bus.m_enable   <= 1'b0;
         bus.m_addr     <= '0;
         bus.m_rw       <= 1'b0;
         bus.m_oplen    <= 2'b00;
         bus.m_unsigned <= 1'b0;
         bus.m_wdata    <= '0;
         bus.i_valid    <= 1'b0;
         bus.i_rdata    <= '0;
         bus.d_valid    <= 1'b0;
         bus.d_rdata    <= '0;
      end else begin
         bus.i_valid <= 1'b0;
         bus.d_valid <= 1'b0;

         case (state)
            ARB_IDLE: begin
               if (winner == OWN_I) begin
                  state          <= ARB_GRANT_I;
                  owner_q        <= OWN_I;
                  tmo_cnt        <= '0;
                  starve_cnt     <= '0;
                  bus.m_enable   <= 1'b1;
                  bus.m_addr     <= bus.i_addr;
                  bus.m_rw       <= 1'b0;
                  bus.m_oplen    <= OPLEN_WORD;
                  bus.m_unsigned <= 1'b0;
                  bus.m_wdata    <= '0;
               end else if (winner == OWN_D) begin
                  state          <= ARB_GRANT_D;
                  owner_q        <= OWN_D;
                  tmo_cnt        <= '0;
                  bus.m_enable   <= 1'b1;
                  bus.m_addr     <= bus.d_addr;
                  bus.m_rw       <= bus.d_rw;
                  bus.m_oplen    <= bus.d_oplen;
                  bus.m_unsigned <= bus.d_unsigned;
                  bus.m_wdata    <= bus.d_wdata;
                  // Only data grants taken over a waiting fetch count toward starvation.
                  if (bus.i_enable) begin
                     if (starve_cnt != STARVE_MAX) begin
                        starve_cnt <= starve_cnt + STARVE_W'(1);
                     end
                  end else begin
                     starve_cnt <= '0;
                  end
               end
            end

            ARB_GRANT_I, ARB_GRANT_D: begin
               if (TIMEOUT_CYCLES != 0) begin
                  if (tmo_cnt != TMO_MAX) begin
                     tmo_cnt <= tmo_cnt + TMO_W'(1);
                  end
                  if (tmo_cnt + TMO_W'(1) == TMO_MAX) begin
                     timeout_err <= 1'b1;
                  end
               end
               if (bus.m_valid) begin
                  bus.m_enable <= 1'b0;
                  state        <= ARB_RELEASE;
                  if (state == ARB_GRANT_I) begin
                     bus.i_rdata <= bus.m_rdata;
                     bus.i_valid <= 1'b1;
                  end else begin
                     bus.d_rdata <= bus.m_rdata;
                     bus.d_valid <= 1'b1;
                  end
               end
            end

            // One dead cycle lets the served requester see valid and drop enable
            // before the next arbitration, so no request is served twice.
            ARB_RELEASE: begin
               owner_q <= OWN_NONE;
               state   <= ARB_IDLE;
            end

            default: begin
               state <= ARB_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single SDRAM controller port between the CPU instruction-fetch requester and the data load/store requester. Both requesters use the codebase's level enable/valid handshake. The block sequences one transaction at a time downstream and routes the result back to the owner. Fairness is data-priority with a starvation guard for fetch. It sits between the CPU core and sdramController.

Parameters:
ADDR_W, 25, SDRAM byte address width
STARVE_LIMIT, 4, consecutive data grants, while fetch is waiting, before fetch is forced to win (1..15)
TIMEOUT_CYCLES, 1023, grant duration that sets timeout_err; 0 disables the check

Ports:
clk  in  1  system clock, all logic on posedge
rst_n  in  1  asynchronous active-low reset
i_enable  in  1  fetch request; held high until i_valid is seen
i_addr  in  ADDR_W  fetch address
i_valid  out  1  one-cycle pulse: i_rdata valid
i_rdata  out  32  fetched word
d_enable  in  1  data request; held high until d_valid is seen
d_addr  in  ADDR_W  data address
d_rw  in  1  0=load, 1=store
d_oplen  in  2  access size, passed through unchanged
d_unsigned  in  1  load zero-extend flag, passed through
d_wdata  in  32  store data
d_valid  out  1  one-cycle pulse: d_rdata valid / store done
d_rdata  out  32  load result
m_enable  out  1  downstream request, held until m_valid
m_addr  out  ADDR_W  downstream address
m_rw, m_oplen, m_unsigned, m_wdata  out  1,2,1,32  downstream attributes
m_valid  in  1  downstream completion pulse
m_rdata  in  32  downstream read data
owner  out  2  00 none, 01 fetch, 10 data
timeout_err  out  1  sticky grant-timeout flag

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transaction):
  - all outputs 0; state IDLE; starvation counter 0; timeout counter 0; timeout_err 0.
  - A downstream transaction in flight is abandoned; its later m_valid is ignored.
- States: IDLE, GRANT_I, GRANT_D, RELEASE.
- IDLE:
  - Only d_enable high -> GRANT_D. Only i_enable high -> GRANT_I. Neither -> stay.
  - Both high -> GRANT_D, unless starve_cnt == STARVE_LIMIT, in which case GRANT_I.
- On the grant edge:
  - Requester fields are registered into m_* with m_enable=1. For fetch: m_rw=0, m_oplen=2'b10, m_unsigned=0, m_wdata=0.
  - m_* fields are stable for the whole grant. Requester inputs are not re-sampled.
  - owner updates on the same edge.
- Starvation counter:
  - Increments on a data grant while i_enable is high, saturating at STARVE_LIMIT.
  - Clears on any fetch grant, and on a data grant with i_enable low.
- GRANT_x:
  - Wait for m_valid. Cycle of m_valid = T. At edge T: m_enable<=0, x_rdata<=m_rdata (d_rdata gets m_rdata on stores too), x_valid<=1, state<=RELEASE.
  - x_valid is high for cycle T+1 only.
  - x_rdata holds its value until the next completion for that port.
- RELEASE: one cycle, owner<=00, then IDLE.
  - This guarantees re-arbitration at T+2, after the requester has sampled valid and dropped enable, so one request is never served twice.
- Minimum turnaround is 3 cycles plus downstream latency (request seen in IDLE -> m_enable next cycle).
- Requester drops enable during its grant: the transaction still completes and valid still pulses.
- m_valid outside GRANT_x: ignored.
- Timeout:
  - Counter runs during GRANT_x and clears on entry.
  - Reaching TIMEOUT_CYCLES (if nonzero) sets timeout_err, which stays set until reset.
  - The grant keeps waiting.
- Both enables low forever: stays IDLE, m_enable=0.

Decomposition:
- Shared package gets:
  - arbstate_t enum (ARB_IDLE, ARB_GRANT_I, ARB_GRANT_D, ARB_RELEASE);
  - owner_t enum (OWN_NONE=2'b00, OWN_I=2'b01, OWN_D=2'b10);
  - OPLEN_WORD=2'b10 constant.
- One sub-module, arb_prio, is natural: pure-combinational winner select from (i_enable, d_enable, starve_cnt == STARVE_LIMIT).
- The counters and FSM stay in mem_arbiter.

Test Plan:
- Fetch only, addr 0x000100, downstream m_valid 5 cycles after m_enable with m_rdata 0x00000013 -> m_addr=0x000100, m_rw=0; i_rdata=0x00000013; i_valid one cycle; d_valid never.
- Load and fetch asserted in the same IDLE cycle (d_addr 0x0040, oplen 00, unsigned 1) -> data granted first, owner=10, m_unsigned=1; fetch granted after RELEASE; i_valid follows d_valid by ≥3 cycles.
- Data requester re-requests continuously with fetch pending, STARVE_LIMIT=4 -> exactly 4 data grants, then a fetch grant, then the counter is cleared.
- Store d_wdata 0xDEADBEEF, oplen 01 -> m_wdata=0xDEADBEEF, m_rw=1, m_oplen=01; d_valid pulses once; no second store issued.
- rst_n low for 1 cycle while in GRANT_D, then m_valid arrives -> m_enable, owner, and both valids 0 immediately; the stale m_valid produces no valid pulse.
- TIMEOUT_CYCLES=8, m_valid withheld 20 cycles -> timeout_err rises after cycle 8 of the grant, stays 1; the transaction still completes when m_valid arrives.
